// File: rtl/instr_fetch_queue.sv
// Byte-stream instruction assembler with opcode screening, feeding a small FIFO
// that presents instructions to the compute unit over valid/ready.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  output logic [15:0]                  instr_out,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         opcode_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      hi_reg;
  logic [15:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic            err_q;

  logic            byte_acc;
  logic [15:0]     word;
  logic            push;
  logic            drop;
  logic            pop;

  // Assembler next-state, byte handshake and push/drop decode
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b1;
    byte_acc   = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    word       = {hi_reg, byte_in};

    if (state == S_LO) begin
      byte_ready = (count_q != CW'(DEPTH));
    end
    byte_acc = byte_valid && byte_ready;

    case (state)
      S_HI: begin
        if (byte_acc) begin
          state_nxt = S_LO;
        end
      end
      S_LO: begin
        if (byte_acc) begin
          state_nxt = S_HI;
          // Opcodes 8..F are undefined: bit 15 alone identifies them
          if (word[15]) begin
            drop = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_nxt = S_HI;
    endcase
  end

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_out   = instr_valid ? mem[rd_ptr] : 16'h0000;
  assign count       = count_q;
  assign opcode_err  = err_q;

  // Assembler state and held high byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_HI;
      hi_reg <= 8'h00;
    end else if (flush) begin
      state  <= S_HI;
    end else begin
      state <= state_nxt;
      if (state == S_HI && byte_acc) begin
        hi_reg <= byte_in;
      end
    end
  end

  // FIFO storage; contents are never visible while empty, so no reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= word;
    end
  end

  // FIFO pointers, occupancy and sticky opcode error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (drop) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  count;
  logic        opcode_err;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .count       (count),
    .opcode_err  (opcode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instruction queue, pending high byte, sticky error
  logic [15:0] mq[$];
  bit          m_hi_v;
  logic [7:0]  m_hi;
  bit          m_err;

  task automatic mdl_clear();
    mq.delete();
    m_hi_v = 0;
    m_hi   = 8'h00;
    m_err  = 0;
  endtask

  task automatic mdl_edge(input logic f, input logic bv, input logic [7:0] b, input logic ir);
    bit          acc;
    logic [15:0] w;
    if (f) begin
      mdl_clear();
    end else begin
      acc = bv && (!m_hi_v || mq.size() != DEPTH);
      if (ir && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        if (!m_hi_v) begin
          m_hi   = b;
          m_hi_v = 1;
        end else begin
          w      = {m_hi, b};
          m_hi_v = 0;
          if (w[15:12] < 4'h8) mq.push_back(w);
          else m_err = 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    logic [15:0] exp_out;
    exp_out = (mq.size() > 0) ? mq[0] : 16'h0000;
    check({tag, ".byte_ready"},  32'(byte_ready),  32'(!m_hi_v || mq.size() != DEPTH));
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(mq.size() != 0));
    check({tag, ".instr_out"},   32'(instr_out),   32'(exp_out));
    check({tag, ".count"},       32'(count),       32'(mq.size()));
    check({tag, ".opcode_err"},  32'(opcode_err),  32'(m_err));
  endtask

  // One clock: drive inputs, model the edge, compare at the falling edge
  task automatic cyc(input logic f, input logic bv, input logic [7:0] b, input logic ir, input string tag);
    flush       = f;
    byte_valid  = bv;
    byte_in     = b;
    instr_ready = ir;
    @(posedge clk);
    mdl_edge(f, bv, b, ir);
    @(negedge clk);
    flush       = 1'b0;
    byte_valid  = 1'b0;
    byte_in     = 8'h00;
    instr_ready = 1'b0;
    cmp_model(tag);
  endtask

  typedef struct {
    logic        f;
    logic        bv;
    logic [7:0]  b;
    logic        ir;
    logic        br;
    logic        v;
    logic [15:0] out;
    int          cnt;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic f, logic bv, logic [7:0] b, logic ir,
                              logic br, logic v, logic [15:0] out, int cnt, logic err);
    vec_t r;
    r.f = f; r.bv = bv; r.b = b; r.ir = ir;
    r.br = br; r.v = v; r.out = out; r.cnt = cnt; r.err = err;
    return r;
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, ".byte_ready"},  32'(byte_ready),  32'd1);
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, ".instr_out"},   32'(instr_out),   32'h0);
    check({tag, ".count"},       32'(count),       32'd0);
    check({tag, ".opcode_err"},  32'(opcode_err),  32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; instr_ready = 1'b0;
    mdl_clear();
    #2;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed table: inputs for one cycle, outputs expected after that edge
    //                f  bv  byte  ir  br  v   out      cnt err
    vecs.push_back(mk(0, 1, 8'h13, 0, 1, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 16'h13A5, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 8'h80, 0, 1, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 8'h12, 0, 1, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 1, 8'h21, 0, 1, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 16'h2100, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 1, 8'h10, 0, 1, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 1, 8'h01, 0, 1, 1, 16'h1001, 1, 1));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 1, 16'h1001, 1, 1));
    vecs.push_back(mk(0, 1, 8'h02, 0, 1, 1, 16'h1001, 2, 1));
    vecs.push_back(mk(0, 1, 8'h50, 0, 1, 1, 16'h1001, 2, 1));
    vecs.push_back(mk(0, 1, 8'h34, 1, 1, 1, 16'h1102, 2, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 16'h5034, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 1, 8'h22, 0, 1, 1, 16'h1122, 1, 1));
    vecs.push_back(mk(0, 1, 8'h33, 0, 1, 1, 16'h1122, 1, 1));
    vecs.push_back(mk(0, 1, 8'h44, 0, 1, 1, 16'h1122, 2, 1));
    vecs.push_back(mk(0, 1, 8'h55, 0, 1, 1, 16'h1122, 2, 1));
    vecs.push_back(mk(0, 1, 8'h66, 0, 1, 1, 16'h1122, 3, 1));
    vecs.push_back(mk(0, 1, 8'h77, 0, 1, 1, 16'h1122, 3, 1));
    vecs.push_back(mk(1, 1, 8'h88, 0, 1, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 1, 1, 16'h1122, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 16'h0000, 0, 0));

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      cyc(vecs[i].f, vecs[i].bv, vecs[i].b, vecs[i].ir, {t, ".mdl"});
      check({t, ".byte_ready"},  32'(byte_ready),  32'(vecs[i].br));
      check({t, ".instr_valid"}, 32'(instr_valid), 32'(vecs[i].v));
      check({t, ".instr_out"},   32'(instr_out),   32'(vecs[i].out));
      check({t, ".count"},       32'(count),       32'(vecs[i].cnt));
      check({t, ".opcode_err"},  32'(opcode_err),  32'(vecs[i].err));
    end

    // Full FIFO: pending low byte blocked even while a pop happens
    begin
      logic [7:0] fill [9];
      logic [15:0] order [4];
      fill = '{8'h10, 8'h01, 8'h11, 8'h02, 8'h22, 8'h01, 8'h30, 8'h12, 8'h40};
      foreach (fill[i]) cyc(0, 1, fill[i], 0, "fill");
      check("full.count", 32'(count), 32'd4);
      check("full.byte_ready", 32'(byte_ready), 32'd0);
      cyc(0, 1, 8'h07, 1, "full.pop");
      check("full.pop.count", 32'(count), 32'd3);
      check("full.pop.byte_ready", 32'(byte_ready), 32'd1);
      check("full.pop.head", 32'(instr_out), 32'h1102);
      cyc(0, 1, 8'h07, 0, "full.low");
      check("full.low.count", 32'(count), 32'd4);
      order = '{16'h1102, 16'h2201, 16'h3012, 16'h4007};
      foreach (order[i]) begin
        check($sformatf("full.drain%0d", i), 32'(instr_out), 32'(order[i]));
        cyc(0, 0, 8'h00, 1, "drain");
      end
      check("full.empty", 32'(instr_valid), 32'd0);
    end

    // Asynchronous reset between edges, with a high byte pending
    begin
      logic [7:0] pre [5];
      pre = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h90};
      foreach (pre[i]) cyc(0, 1, pre[i], 0, "prerst");
      check("prerst.count", 32'(count), 32'd2);
      #2 rst = 1'b1;
      #1;
      reset_checks("async_rst");
      mdl_clear();
      @(negedge clk);
      rst = 1'b0;
      cyc(0, 1, 8'h12, 0, "postrst.hi");
      cyc(0, 1, 8'h34, 0, "postrst.lo");
      check("postrst.word", 32'(instr_out), 32'h1234);
      cyc(0, 0, 8'h00, 1, "postrst.pop");
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic f, bv, ir;
      logic [7:0] b;
      f  = ($urandom_range(0, 39) == 0);
      bv = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 2) == 0);
      b  = 8'($urandom);
      cyc(f, bv, b, ir, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
